exec_mem_unit: RTL and testbench
================================

Name: exec_mem_unit

Overview:
- Combined decode / execute / data-memory slice of the 8-bit multi-cycle CPU.
- The CPU sequencer supplies the fetched instruction, PC, register-file read data and memory address/write data.
- It pulses a one-cycle strobe per stage: decode, execute, memory.
- The block returns register addresses and control flags, the ALU result with jump mask and overflow, and memory read data.

Parameters:
- DATA_W, 8, datapath/instruction width
- MEM_DEPTH, 256, data memory words (address width 8)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- instruction  in  8  [7:4] opcode, [3:2] field A, [1:0] field B
- pc  in  8  PC of the current instruction
- dec_en  in  1  decode strobe
- exe_en  in  1  execute strobe
- mem_en  in  1  memory-access strobe
- reg_data_0  in  8  value of R[reg_addr_0]
- reg_data_1  in  8  value of R[reg_addr_1]
- mem_address  in  8  data memory address
- mem_data_w  in  8  data memory write data
- reg_addr_0, reg_addr_1, reg_addr_w  out  2 each  source/destination register indices
- reg_w_en, mem_w_en, mem_r_en  out  1 each  enables
- sel_w_source  out  8  0xFF = writeback from memory, 0x00 = from ALU
- alu_result  out  8  ALU result or jump offset
- jump  out  8  0xFF = take PC offset, 0x00 = PC+1
- overflow  out  1  signed overflow
- mem_data_r  out  8  registered read data

Behaviour:

Reset (rst_n low, asynchronous):
- All outputs go to 0.
- All MEM_DEPTH memory words clear to 0.
- Reset mid-operation abandons any pending strobe action.

Decode (rising clk with dec_en):
- Registers reg_addr_*, reg_w_en, mem_w_en, mem_r_en and sel_w_source from the instruction, per the opcode table below.
- Default assignment: reg_addr_0 = A, reg_addr_1 = B, reg_addr_w = A.
- Outputs hold until the next dec_en.

Execute (rising clk with exe_en):
- Registers alu_result, jump and overflow.
- Operands are in0 = reg_data_0 and in1 = reg_data_1.
- All arithmetic is modulo 256.
- overflow is signed overflow for add, sub and addi; 0 for every other opcode.

Opcode table:
- 0000 halt/nop: no enables, result 0, jump 0.
- 0001 add: R[A] = in0 + in1, reg_w_en.
- 0010 sub: R[A] = in0 - in1, reg_w_en.
- 0011 and; 0100 or: bitwise, reg_w_en.
- 0101 slt: result 1 if signed in0 < in1, else 0; reg_w_en.
- 0110 sll: result = in0 << in1[2:0]; reg_w_en.
- 0111 addi: result = in0 + sign-extended B; reg_w_en.
- 1000 j: result = sign-extended instruction[3:0]; jump 0xFF.
- 1001 jal: same result/jump as j; mem_w_en = 1; reg_w_en = 0. The sequencer writes pc+1 to address R3+1.
- 1010 lw: reg_addr_0 = B (address), reg_addr_w = A, mem_r_en, reg_w_en, sel_w_source 0xFF; result = in0.
- 1011 sw: reg_addr_0 = B (address), reg_addr_1 = A (data), mem_w_en; result = in0.
- 1100 beq; 1101 bne: compare in0 and in1 (A, B). When taken: jump 0xFF, result 1 (skip next instruction). Otherwise jump 0 and result 0. No enables.
- 1110 li: R[A] = zero-extended B, reg_w_en.
- 1111 not: reg_addr_0 = B; R[A] = ~in0, reg_w_en.

Memory (rising clk with mem_en):
- mem_data_r <= M[mem_address] on every strobe; read-before-write, so it returns the old value.
- If mem_w_en is set, M[mem_address] <= mem_data_w.
- Without mem_en: memory and mem_data_r hold.

Strobe concurrency:
- Strobes are mutually exclusive in normal use.
- If several are asserted together, each stage acts independently on the same edge, using pre-edge register values.

Test Plan:
- Reset: rst_n low mid-sequence -> all outputs 0; a later read of address 0x10 returns 0x00.
- Add overflow: instruction 0x11 (add R0,R1) with in0 = 0x7F, in1 = 0x01 -> reg_w_en 1, addr_w 0, alu_result 0x80, overflow 1, jump 0x00.
- Store/load: sw 0xB1 with in0 = 0x20, data 0x5A, mem_address 0x20, mem_en -> a following lw 0xA1 read returns mem_data_r 0x5A; sel_w_source 0xFF.
- Branch: beq 0xC1 with in0 = in1 = 0x33 -> jump 0xFF, alu_result 0x01. With in1 = 0x34 -> jump 0x00, alu_result 0x00.
- Jump and link: jal 0x9E -> mem_w_en 1, reg_w_en 0, jump 0xFF, alu_result 0xFE.
- Sub/slt: sub 0x20 of 0x00 - 0x01 -> 0xFF, overflow 0. slt with 0x80 vs 0x01 -> 0x01.

Source files
------------

// File: rtl/exec_mem_unit.sv
// exec_mem_unit: decode, execute and data-memory slice of the 8-bit multi-cycle CPU
module exec_mem_unit #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] pc,
    input  logic              dec_en,
    input  logic              exe_en,
    input  logic              mem_en,
    input  logic [DATA_W-1:0] reg_data_0,
    input  logic [DATA_W-1:0] reg_data_1,
    input  logic [AW-1:0]     mem_address,
    input  logic [DATA_W-1:0] mem_data_w,
    output logic [1:0]        reg_addr_0,
    output logic [1:0]        reg_addr_1,
    output logic [1:0]        reg_addr_w,
    output logic              reg_w_en,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic [DATA_W-1:0] sel_w_source,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] jump,
    output logic              overflow,
    output logic [DATA_W-1:0] mem_data_r
);
    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR = 4'h4,
                           OP_SLT = 4'h5, OP_SLL = 4'h6, OP_ADDI = 4'h7, OP_J = 4'h8,
                           OP_JAL = 4'h9, OP_LW = 4'hA, OP_SW = 4'hB, OP_BEQ = 4'hC,
                           OP_BNE = 4'hD, OP_LI = 4'hE, OP_NOT = 4'hF;
    logic [3:0]        w_op;
    logic [1:0]        w_fa, w_fb, w_a0, w_a1, w_aw;
    logic              w_rwe, w_mwe, w_mre, w_ovf;
    logic [DATA_W-1:0] w_sel, w_res, w_jmp, w_sx4, w_sxb, w_sum, w_dif, w_addi;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    assign w_op   = instruction[7:4];
    assign w_fa   = instruction[3:2];
    assign w_fb   = instruction[1:0];
    assign w_sx4  = {{(DATA_W-4){instruction[3]}}, instruction[3:0]};
    assign w_sxb  = {{(DATA_W-2){instruction[1]}}, instruction[1:0]};
    assign w_sum  = reg_data_0 + reg_data_1;
    assign w_dif  = reg_data_0 - reg_data_1;
    assign w_addi = reg_data_0 + w_sxb;
    // Control decode: register indices default to A/B/A, address-using ops read B
    always_comb begin
        w_a0  = (w_op == OP_LW || w_op == OP_SW || w_op == OP_NOT) ? w_fb : w_fa;
        w_a1  = (w_op == OP_SW) ? w_fa : w_fb;
        w_aw  = w_fa;
        w_rwe = (w_op >= OP_ADD && w_op <= OP_ADDI) || w_op == OP_LW || w_op == OP_LI || w_op == OP_NOT;
        w_mwe = (w_op == OP_JAL || w_op == OP_SW);
        w_mre = (w_op == OP_LW);
        w_sel = (w_op == OP_LW) ? '1 : '0;
    end
    // ALU: result, jump mask and signed overflow for add/sub/addi
    always_comb begin
        w_res = '0;
        w_jmp = '0;
        w_ovf = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (reg_data_0[DATA_W-1] == reg_data_1[DATA_W-1]) && (w_sum[DATA_W-1] != reg_data_0[DATA_W-1]);
            end
            OP_SUB: begin
                w_res = w_dif;
                w_ovf = (reg_data_0[DATA_W-1] != reg_data_1[DATA_W-1]) && (w_dif[DATA_W-1] != reg_data_0[DATA_W-1]);
            end
            OP_AND:  w_res = reg_data_0 & reg_data_1;
            OP_OR:   w_res = reg_data_0 | reg_data_1;
            OP_SLT:  w_res = ($signed(reg_data_0) < $signed(reg_data_1)) ? DATA_W'(1) : '0;
            OP_SLL:  w_res = reg_data_0 << reg_data_1[2:0];
            OP_ADDI: begin
                w_res = w_addi;
                w_ovf = (reg_data_0[DATA_W-1] == w_sxb[DATA_W-1]) && (w_addi[DATA_W-1] != reg_data_0[DATA_W-1]);
            end
            OP_J, OP_JAL: begin
                w_res = w_sx4;
                w_jmp = '1;
            end
            OP_LW, OP_SW: w_res = reg_data_0;
            OP_BEQ, OP_BNE: begin
                w_res = ((reg_data_0 == reg_data_1) == (w_op == OP_BEQ)) ? DATA_W'(1) : '0;
                w_jmp = ((reg_data_0 == reg_data_1) == (w_op == OP_BEQ)) ? '1 : '0;
            end
            OP_LI:   w_res = {{(DATA_W-2){1'b0}}, w_fb};
            OP_NOT:  w_res = ~reg_data_0;
            default: w_res = '0;
        endcase
    end
    // Decode stage: latch control outputs on the decode strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_addr_0   <= '0;
            reg_addr_1   <= '0;
            reg_addr_w   <= '0;
            reg_w_en     <= 1'b0;
            mem_w_en     <= 1'b0;
            mem_r_en     <= 1'b0;
            sel_w_source <= '0;
        end else if (dec_en) begin
            reg_addr_0   <= w_a0;
            reg_addr_1   <= w_a1;
            reg_addr_w   <= w_aw;
            reg_w_en     <= w_rwe;
            mem_w_en     <= w_mwe;
            mem_r_en     <= w_mre;
            sel_w_source <= w_sel;
        end
    end
    // Execute stage: latch ALU outputs on the execute strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= '0;
            jump       <= '0;
            overflow   <= 1'b0;
        end else if (exe_en) begin
            alu_result <= w_res;
            jump       <= w_jmp;
            overflow   <= w_ovf;
        end
    end
    // Memory stage: read-before-write, write gated by the decoded write enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data_r <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
        end else if (mem_en) begin
            mem_data_r <= r_mem[mem_address];
            if (mem_w_en) r_mem[mem_address] <= mem_data_w;
        end
    end
    logic w_unused;
    assign w_unused = ^pc;
endmodule

// File: tb/tb_exec_mem_unit.sv
// tb_exec_mem_unit: scoreboard bench for exec_mem_unit decode, execute and memory stages
module tb_exec_mem_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] instruction = '0, pc = '0, reg_data_0 = '0, reg_data_1 = '0;
    logic [7:0] mem_address = '0, mem_data_w = '0;
    logic       dec_en = 1'b0, exe_en = 1'b0, mem_en = 1'b0;
    logic [1:0] reg_addr_0, reg_addr_1, reg_addr_w;
    logic       reg_w_en, mem_w_en, mem_r_en, overflow;
    logic [7:0] sel_w_source, alu_result, jump, mem_data_r;

    typedef struct {
        string       tag;
        int          kind;
        logic [16:0] exp;
    } exp_t;
    exp_t       q[$];
    logic [7:0] mm[256];
    logic       cur_mwe = 1'b0;
    int         n_chk = 0, n_err = 0;

    exec_mem_unit dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc(pc),
        .dec_en(dec_en), .exe_en(exe_en), .mem_en(mem_en),
        .reg_data_0(reg_data_0), .reg_data_1(reg_data_1),
        .mem_address(mem_address), .mem_data_w(mem_data_w),
        .reg_addr_0(reg_addr_0), .reg_addr_1(reg_addr_1), .reg_addr_w(reg_addr_w),
        .reg_w_en(reg_w_en), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
        .sel_w_source(sel_w_source), .alu_result(alu_result), .jump(jump),
        .overflow(overflow), .mem_data_r(mem_data_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] obs(input int kind);
        case (kind)
            0:       return {reg_addr_0, reg_addr_1, reg_addr_w, reg_w_en, mem_w_en, mem_r_en, sel_w_source};
            1:       return {alu_result, jump, overflow};
            default: return {9'b0, mem_data_r};
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, obs(e.kind), e.exp);
        end
    endtask

    // {a0,a1,aw,reg_w_en,mem_w_en,mem_r_en,sel}
    function automatic logic [16:0] m_dec(input logic [7:0] ins);
        logic [1:0] a = ins[3:2], b = ins[1:0];
        case (ins[7:4])
            4'h0, 4'h8, 4'hC, 4'hD: return {a, b, a, 3'b000, 8'h00};
            4'h9:                   return {a, b, a, 3'b010, 8'h00};
            4'hA:                   return {b, b, a, 3'b101, 8'hFF};
            4'hB:                   return {b, a, a, 3'b010, 8'h00};
            4'hF:                   return {b, b, a, 3'b100, 8'h00};
            default:                return {a, b, a, 3'b100, 8'h00};
        endcase
    endfunction

    // {alu_result,jump,overflow}
    function automatic logic [16:0] m_exe(input logic [7:0] ins, input logic [7:0] x, input logic [7:0] y);
        int         sx = $signed(x), sy = $signed(y), s = 0;
        logic [7:0] r = 8'h00, j = 8'h00;
        bit         o = 0;
        case (ins[7:4])
            4'h1: begin r = x + y; s = sx + sy; o = (s > 127 || s < -128); end
            4'h2: begin r = x - y; s = sx - sy; o = (s > 127 || s < -128); end
            4'h3: r = x & y;
            4'h4: r = x | y;
            4'h5: r = (sx < sy) ? 8'd1 : 8'd0;
            4'h6: r = x << y[2:0];
            4'h7: begin s = sx + $signed(ins[1:0]); r = 8'(s); o = (s > 127 || s < -128); end
            4'h8, 4'h9: begin r = 8'($signed(ins[3:0])); j = 8'hFF; end
            4'hA, 4'hB: r = x;
            4'hC: begin r = (x == y) ? 8'd1 : 8'd0; j = (x == y) ? 8'hFF : 8'h00; end
            4'hD: begin r = (x != y) ? 8'd1 : 8'd0; j = (x != y) ? 8'hFF : 8'h00; end
            4'hE: r = {6'b0, ins[1:0]};
            4'hF: r = ~x;
            default: r = 8'h00;
        endcase
        return {r, j, o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1 drain();
        @(negedge clk);
        dec_en = 1'b0;
        exe_en = 1'b0;
        mem_en = 1'b0;
    endtask

    task automatic dec(input string tag, input logic [7:0] ins, input logic [16:0] exp);
        instruction = ins;
        dec_en = 1'b1;
        q.push_back('{tag, 0, exp});
        cur_mwe = exp[9];
        step();
    endtask

    task automatic exe(input string tag, input logic [7:0] ins, input logic [7:0] x, input logic [7:0] y, input logic [16:0] exp);
        instruction = ins;
        reg_data_0 = x;
        reg_data_1 = y;
        exe_en = 1'b1;
        q.push_back('{tag, 1, exp});
        step();
    endtask

    task automatic mem(input string tag, input logic [7:0] addr, input logic [7:0] data, input logic [7:0] exp);
        mem_address = addr;
        mem_data_w = data;
        mem_en = 1'b1;
        q.push_back('{tag, 2, {9'b0, exp}});
        if (cur_mwe) mm[addr] = data;
        step();
    endtask

    initial begin
        logic [7:0] ins, x, y, ad;
        for (int i = 0; i < 256; i++) mm[i] = 8'h00;
        #12;
        q.push_back('{"rst_dec", 0, 17'h0});
        q.push_back('{"rst_exe", 1, 17'h0});
        q.push_back('{"rst_mem", 2, 17'h0});
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        dec("add_dec", 8'h11, {2'd0, 2'd1, 2'd0, 3'b100, 8'h00});
        exe("add_ovf", 8'h11, 8'h7F, 8'h01, {8'h80, 8'h00, 1'b1});
        exe("sub", 8'h20, 8'h00, 8'h01, {8'hFF, 8'h00, 1'b0});
        exe("slt", 8'h51, 8'h80, 8'h01, {8'h01, 8'h00, 1'b0});
        dec("sw_dec", 8'hB1, {2'd1, 2'd0, 2'd0, 3'b010, 8'h00});
        exe("sw_exe", 8'hB1, 8'h20, 8'h5A, {8'h20, 8'h00, 1'b0});
        mem("sw_mem", 8'h20, 8'h5A, 8'h00);
        dec("lw_dec", 8'hA1, {2'd1, 2'd1, 2'd0, 3'b101, 8'hFF});
        mem("lw_mem", 8'h20, 8'h77, 8'h5A);
        mem("lw_again", 8'h20, 8'h00, 8'h5A);
        exe("beq_t", 8'hC1, 8'h33, 8'h33, {8'h01, 8'hFF, 1'b0});
        exe("beq_nt", 8'hC1, 8'h33, 8'h34, {8'h00, 8'h00, 1'b0});
        exe("bne_t", 8'hD1, 8'h33, 8'h34, {8'h01, 8'hFF, 1'b0});
        dec("jal_dec", 8'h9E, {2'd3, 2'd2, 2'd3, 3'b010, 8'h00});
        exe("jal_exe", 8'h9E, 8'h00, 8'h00, {8'hFE, 8'hFF, 1'b0});
        exe("addi_ovf", 8'h71, 8'h7F, 8'h00, {8'h80, 8'h00, 1'b1});
        exe("addi_neg", 8'h73, 8'h00, 8'h00, {8'hFF, 8'h00, 1'b0});

        for (int i = 0; i < 40; i++) begin
            ins = 8'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            ad = 8'($urandom_range(0, 15));
            dec("rnd_dec", ins, m_dec(ins));
            exe("rnd_exe", ins, x, y, m_exe(ins, x, y));
            mem("rnd_mem", ad, 8'($urandom), mm[ad]);
        end

        dec("pre_rst_sw", 8'hB1, m_dec(8'hB1));
        mem("pre_rst_wr", 8'h10, 8'hC3, mm[8'h10]);
        instruction = 8'h11;
        reg_data_0 = 8'h7F;
        reg_data_1 = 8'h01;
        dec_en = 1'b1;
        exe_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        q.push_back('{"mid_rst_dec", 0, 17'h0});
        q.push_back('{"mid_rst_exe", 1, 17'h0});
        q.push_back('{"mid_rst_mem", 2, 17'h0});
        drain();
        @(negedge clk);
        dec_en = 1'b0;
        exe_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) mm[i] = 8'h00;
        cur_mwe = 1'b0;
        @(negedge clk);
        dec("post_rst_lw", 8'hA1, {2'd1, 2'd1, 2'd0, 3'b101, 8'hFF});
        mem("post_rst_rd10", 8'h10, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
